// File: rtl/rgb2gray_pkg.sv
// Shared state encoding and default sizing for the RGB-to-gray frame sequencer.
package rgb2gray_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_WAIT,
      CONV,
      WR,
      DONE
   } state_t;

   localparam int DEF_ADDRWIDTH = 18;
   localparam int DEF_NPIX      = 262144;
   localparam int PIX_DW        = 24;

   typedef logic [PIX_DW-1:0] pix_dat_t;

endpackage

// File: rtl/rgb2gray_pix_cnt.sv
// Pixel address register: cleared at frame start and wrap, stepped after each write.
module rgb2gray_pix_cnt
   import rgb2gray_pkg::*;
#(
   parameter int ADDRWIDTH = DEF_ADDRWIDTH,
   parameter int NPIX      = DEF_NPIX
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 clear,
   input  logic                 incr,
   output logic [ADDRWIDTH-1:0] addr,
   output logic                 last
);

   localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NPIX - 1);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         addr <= '0;
      end else if (clear) begin
         addr <= '0;
      end else if (incr) begin
         addr <= addr + ADDRWIDTH'(1);
      end
   end

   assign last = (addr == LAST_ADDR);

endmodule

// File: rtl/rgb2gray_frame_ctrl.sv
// Frame sequencer: read pixel, launch converter, wait for done (with timeout), write gray.
// Outputs decode only registered state/counters, so start/abort/conv_done never reach them combinationally.
module rgb2gray_frame_ctrl
   import rgb2gray_pkg::*;
#(
   parameter int ADDRWIDTH = DEF_ADDRWIDTH,
   parameter int NPIX      = DEF_NPIX,
   parameter int RD_LAT    = 1,
   parameter int TIMEOUT   = 15
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 start,
   input  logic                 abort,
   output logic                 rd_en,
   output logic [ADDRWIDTH-1:0] rd_addr,
   output logic                 conv_start,
   input  logic                 conv_done,
   output logic                 wr_en,
   output logic [ADDRWIDTH-1:0] wr_addr,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 err
);

   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

   state_t               state;
   state_t               state_nxt;
   logic [LW-1:0]        lat_cnt;
   logic [TW-1:0]        tmo_cnt;
   logic                 pix_clr;
   logic                 pix_inc;
   logic                 pix_last;
   logic                 err_set;
   logic                 err_clr;
   logic [ADDRWIDTH-1:0] pix;

   rgb2gray_pix_cnt #(
      .ADDRWIDTH (ADDRWIDTH),
      .NPIX      (NPIX)
   ) u_pix_cnt (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .clear (pix_clr),
      .incr  (pix_inc),
      .addr  (pix),
      .last  (pix_last)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // tmo_cnt is 0 exactly in the first CONV cycle; it saturates at TIMEOUT.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         lat_cnt <= '0;
         tmo_cnt <= '0;
      end else begin
         if (state == RD) begin
            lat_cnt <= LAT_INIT;
         end else if (state == RD_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LW'(1);
         end
         if (state != CONV) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         err <= 1'b0;
      end else if (err_clr) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      pix_clr   = 1'b0;
      pix_inc   = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = RD;
               pix_clr   = 1'b1;
               err_clr   = 1'b1;
            end
         end
         RD: state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (lat_cnt == '0) begin
               state_nxt = CONV;
            end
         end
         CONV: begin
            if (tmo_cnt != '0 && conv_done) begin
               state_nxt = WR;
            end else if (tmo_cnt == TMO_MAX) begin
               state_nxt = IDLE;
               err_set   = 1'b1;
            end
         end
         WR: begin
            if (pix_last) begin
               state_nxt = DONE;
            end else begin
               state_nxt = RD;
               pix_inc   = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            pix_clr   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort overrides every transition and suppresses all side effects.
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         pix_clr   = 1'b0;
         pix_inc   = 1'b0;
         err_set   = 1'b0;
      end
   end

   assign rd_en      = (state == RD);
   assign rd_addr    = pix;
   assign conv_start = (state == CONV) && (tmo_cnt == '0);
   assign wr_en      = (state == WR);
   assign wr_addr    = pix;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_rgb2gray_frame_ctrl.sv
// Scoreboarded bench: a timeline model predicts every strobe; a monitor compares what the DUT emits.
module tb_rgb2gray_frame_ctrl;

   localparam int AW      = 4;
   localparam int NP      = 4;
   localparam int RD_LAT  = 1;
   localparam int TIMEOUT = 3;

   localparam int K_RD = 0;
   localparam int K_CS = 1;
   localparam int K_WR = 2;
   localparam int K_FD = 3;

   typedef struct {
      int cyc;
      int kind;
      int addr;
   } ev_t;

   logic          CLK;
   logic          RSTn;
   logic          start;
   logic          abort;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          conv_start;
   logic          conv_done;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          busy;
   logic          frame_done;
   logic          err;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_fail = 0;
   ev_t exp_q[$];
   int  k_q[$];
   bit  e_q[$];
   int  ks[NP];
   bit  ee[NP];

   rgb2gray_frame_ctrl #(
      .ADDRWIDTH (AW),
      .NPIX      (NP),
      .RD_LAT    (RD_LAT),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .start      (start),
      .abort      (abort),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .conv_start (conv_start),
      .conv_done  (conv_done),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1);
   end

   function automatic ev_t mk(input int c, input int k, input int a);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.addr = a;
      return e;
   endfunction

   function automatic string kname(input int k);
      case (k)
         K_RD:    return "rd_en";
         K_CS:    return "conv_start";
         K_WR:    return "wr_en";
         default: return "frame_done";
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon_ev(input int kind, input int addr);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL event: got %s addr %0d at cycle %0d, required no event",
                  kname(kind), addr, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.cyc != cyc || e.kind != kind || e.addr != addr) begin
            n_fail++;
            $display("FAIL event: got %s addr %0d cycle %0d, required %s addr %0d cycle %0d",
                     kname(kind), addr, cyc, kname(e.kind), e.addr, e.cyc);
         end
      end
   endtask

   // Monitor: every strobe the DUT shows is matched against the next predicted event.
   initial forever begin
      @(negedge CLK);
      if (rd_en)      mon_ev(K_RD, int'(rd_addr));
      if (conv_start) mon_ev(K_CS, 0);
      if (wr_en)      mon_ev(K_WR, int'(wr_addr));
      if (frame_done) mon_ev(K_FD, 0);
   end

   // Converter stand-in: k cycles after conv_start it pulses conv_done (k=0: never),
   // optionally also pulsing it in the conv_start cycle itself.
   initial begin
      int kk;
      int n;
      bit ek;
      conv_done = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (conv_start && k_q.size() > 0) begin
            kk = k_q.pop_front();
            ek = e_q.pop_front();
            conv_done = ek;
            n = (kk == 0) ? TIMEOUT : kk;
            for (int i = 1; i <= n; i++) begin
               @(posedge CLK);
               #1;
               conv_done = (i == kk);
            end
            @(posedge CLK);
            #1;
            conv_done = 1'b0;
         end
      end
   end

   // One frame. Cycle b is the cycle start is driven in (cycle 0 of the frame timeline).
   // abort_pix: abort in the 2nd CONV cycle of that pixel; rst_pix: reset during its RD_WAIT.
   task automatic frame(input int abort_pix, input int rst_pix, input bit spur);
      int  b, t, cs, a_cyc, r_cyc, z, lim;
      bit  tmo;
      ev_t evs[$];
      @(posedge CLK);
      #1;
      b = cyc;
      t = b;
      a_cyc = -1;
      r_cyc = -1;
      tmo = 1'b0;
      z = 0;
      k_q.delete();
      e_q.delete();
      for (int p = 0; p < NP; p++) begin
         k_q.push_back(ks[p]);
         e_q.push_back(ee[p]);
      end
      for (int p = 0; p < NP; p++) begin
         evs.push_back(mk(t + 1, K_RD, p));
         cs = t + 2 + RD_LAT;
         evs.push_back(mk(cs, K_CS, 0));
         if (p == abort_pix) a_cyc = cs + 1;
         if (p == rst_pix) r_cyc = t + 2;
         if (ks[p] == 0) begin
            tmo = 1'b1;
            z = cs + TIMEOUT + 1;
            break;
         end
         t = cs + ks[p] + 1;
         evs.push_back(mk(t, K_WR, p));
      end
      if (!tmo) begin
         evs.push_back(mk(t + 1, K_FD, 0));
         z = t + 2;
      end
      lim = z;
      if (a_cyc >= 0) begin
         lim = a_cyc;
         z = a_cyc + 1;
      end
      if (r_cyc >= 0) begin
         lim = r_cyc;
         z = r_cyc;
      end
      foreach (evs[i]) if (evs[i].cyc <= lim) exp_q.push_back(evs[i]);
      start = 1'b1;
      while (cyc < z) begin
         @(posedge CLK);
         #1;
         start = spur && (cyc == b + 4);
         abort = (cyc == a_cyc);
         if (cyc == b + 1) begin
            chk("busy_rise", busy, 1);
            chk("err_cleared_at_start", err, 0);
         end
      end
      if (r_cyc >= 0) begin
         #2;
         RSTn = 1'b0;
         #1;
         chk("rst_strobes", {rd_en, conv_start, wr_en, frame_done}, 0);
         chk("rst_busy_err", {busy, err}, 0);
         chk("rst_addrs", {rd_addr, wr_addr}, 0);
         @(posedge CLK);
         @(posedge CLK);
         #1;
         RSTn = 1'b1;
      end else begin
         chk("busy_fall", busy, 0);
         chk("err_end", err, tmo);
         chk("frame_done_low", frame_done, 0);
      end
      @(negedge CLK);
      #1;
      chk("all_events_seen", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      RSTn  = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      #12;
      chk("reset_strobes", {rd_en, conv_start, wr_en, frame_done}, 0);
      chk("reset_busy_err", {busy, err}, 0);
      chk("reset_addrs", {rd_addr, wr_addr}, 0);
      @(posedge CLK);
      #1;
      RSTn = 1'b1;

      ks = '{2, 2, 2, 2}; ee = '{0, 0, 0, 0};
      frame(-1, -1, 1'b0);

      ks = '{1, 1, 3, 2}; ee = '{1, 0, 1, 1};
      frame(-1, -1, 1'b0);

      ks = '{2, 0, 2, 2}; ee = '{0, 0, 0, 0};
      frame(-1, -1, 1'b0);

      ks = '{1, 2, 3, 1}; ee = '{0, 1, 0, 0};
      frame(-1, -1, 1'b0);

      ks = '{3, 3, 3, 3}; ee = '{0, 0, 0, 0};
      frame(2, -1, 1'b0);

      ks = '{2, 1, 2, 3}; ee = '{0, 0, 0, 0};
      frame(-1, -1, 1'b1);

      // start together with abort in IDLE must not launch a frame
      @(posedge CLK);
      #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", busy, 0);
      @(posedge CLK);
      #1;
      chk("start_abort_idle_2", busy, 0);

      ks = '{2, 2, 2, 2}; ee = '{0, 0, 0, 0};
      frame(-1, 1, 1'b0);
      frame(-1, -1, 1'b0);

      for (int r = 0; r < 5; r++) begin
         for (int p = 0; p < NP; p++) begin
            ks[p] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            ee[p] = 1'($urandom_range(0, 1));
         end
         frame(-1, -1, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
